dsconv_sched: RTL and testbench

- Parametrised sequencer for one depthwise-separable conv layer, one output window at a time.
- Depthwise phase: steps through DW channel groups and drives DW weight-ROM address plus enable.
- Pointwise phase: steps through output-channel × input-channel tiles, drives PW weight-ROM address, accumulator clear and output valid.
- Adds over the previous generation: configurable parallelism, per-layer base addresses, window and output handshakes with backpressure, and explicit layer-done accounting.

---
 rtl/dsconv_sched.sv | 223 ++++++++++++++++++++++
 tb/tb_dsconv_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dsconv_sched.sv
// Sequencer for one depthwise-separable conv layer: DW groups, then PW oc x ic tiles, per output window.
// Latency: window_done comes dw_t + PIPE_LAT + ic_t*oc_t + PIPE_LAT cycles after the window handshake when there is no stall.
// Backpressure: out_valid & ~out_ready freezes state, counters and the result line, and gates every enable and pulse.
module dsconv_sched #(
    parameter int DW_PAR     = 4,
    parameter int PW_IN_PAR  = 8,
    parameter int PW_OUT_PAR = 8,
    parameter int CH_W       = 8,
    parameter int SIZE_W     = 8,
    parameter int DW_ADDR_W  = 5,
    parameter int PW_ADDR_W  = 8,
    parameter int PIPE_LAT   = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CH_W-1:0]      cfg_in_ch,
    input  logic [CH_W-1:0]      cfg_out_ch,
    input  logic [SIZE_W-1:0]    cfg_out_size,
    input  logic [DW_ADDR_W-1:0] cfg_dw_base,
    input  logic [PW_ADDR_W-1:0] cfg_pw_base,
    input  logic                 win_valid,
    output logic                 win_ready,
    input  logic                 out_ready,
    output logic                 dw_en,
    output logic [CH_W-1:0]      dw_grp,
    output logic [DW_ADDR_W-1:0] dw_addr,
    output logic                 pw_en,
    output logic [CH_W-1:0]      pw_ic,
    output logic [CH_W-1:0]      pw_oc,
    output logic [PW_ADDR_W-1:0] pw_addr,
    output logic                 pw_acc_clr,
    output logic                 out_valid,
    output logic [CH_W-1:0]      out_oc,
    output logic                 window_done,
    output logic                 layer_done,
    output logic                 busy
);
    localparam int LAT_W = $clog2(PIPE_LAT + 1);
    localparam int CNT_W = (CH_W > LAT_W) ? CH_W : LAT_W;
    localparam int WIN_W = 2 * SIZE_W;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DW, S_DWD, S_PW, S_PWD} state_t;

    // ceil(n/par), with an empty count still taking one tile
    function automatic logic [CH_W-1:0] tiles(input logic [CH_W-1:0] n, input int par);
        logic [CH_W:0] s;
        s = ({1'b0, n} + (CH_W+1)'(par - 1)) / (CH_W+1)'(par);
        if (n == '0) return CH_W'(1);
        return CH_W'(s);
    endfunction

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CH_W-1:0]      ic_q, ic_d, oc_q, oc_d;
    logic [WIN_W-1:0]     win_q, win_d;
    logic [CH_W-1:0]      dw_t_q, ic_t_q, oc_t_q;
    logic [WIN_W-1:0]     n_win_q;
    logic [DW_ADDR_W-1:0] dw_base_q;
    logic [PW_ADDR_W-1:0] pw_base_q;
    logic [PIPE_LAT-1:0]  vld_line_q;
    logic [CH_W-1:0]      oc_line_q [PIPE_LAT];

    logic                 stall, last_dw, last_lat, last_ic, last_oc, win_last, issue_last;
    logic [SIZE_W-1:0]    size_eff;
    logic [2*CH_W-1:0]    pw_off;

    assign stall      = vld_line_q[PIPE_LAT-1] & ~out_ready;
    assign last_dw    = (cnt_q == CNT_W'(dw_t_q - CH_W'(1)));
    assign last_lat   = (cnt_q == CNT_W'(PIPE_LAT - 1));
    assign last_ic    = (ic_q == ic_t_q - CH_W'(1));
    assign last_oc    = (oc_q == oc_t_q - CH_W'(1));
    assign win_last   = ((win_q + WIN_W'(1)) == n_win_q);
    assign issue_last = (state_q == S_PW) & last_ic & ~stall;
    assign size_eff   = (cfg_out_size == '0) ? SIZE_W'(1) : cfg_out_size;
    assign pw_off     = {{CH_W{1'b0}}, oc_q} * {{CH_W{1'b0}}, ic_t_q} + {{CH_W{1'b0}}, ic_q};

    // state and loop counters; everything holds while stalled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ic_q    <= '0;
            oc_q    <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ic_q    <= ic_d;
            oc_q    <= oc_d;
            win_q   <= win_d;
        end
    end

    // layer configuration, captured only when a start is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dw_t_q    <= CH_W'(1);
            ic_t_q    <= CH_W'(1);
            oc_t_q    <= CH_W'(1);
            n_win_q   <= WIN_W'(1);
            dw_base_q <= '0;
            pw_base_q <= '0;
        end else if (state_q == S_IDLE && start) begin
            dw_t_q    <= tiles(cfg_in_ch, DW_PAR);
            ic_t_q    <= tiles(cfg_in_ch, PW_IN_PAR);
            oc_t_q    <= tiles(cfg_out_ch, PW_OUT_PAR);
            n_win_q   <= {{SIZE_W{1'b0}}, size_eff} * {{SIZE_W{1'b0}}, size_eff};
            dw_base_q <= cfg_dw_base;
            pw_base_q <= cfg_pw_base;
        end
    end

    // result delay line: last-ic issue flag plus its oc, PIPE_LAT stages
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_line_q <= '0;
            for (int i = 0; i < PIPE_LAT; i++) oc_line_q[i] <= '0;
        end else if (!stall) begin
            vld_line_q[0] <= issue_last;
            oc_line_q[0] <= issue_last ? oc_q : '0;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_line_q[i] <= vld_line_q[i-1];
                oc_line_q[i] <= oc_line_q[i-1];
            end
        end
    end

    // next state and counter updates
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ic_d    = ic_q;
        oc_d    = oc_q;
        win_d   = win_q;
        if (!stall) begin
            case (state_q)
                S_IDLE: if (start) state_d = S_WAIT;
                S_WAIT: if (win_valid) begin
                    state_d = S_DW;
                    cnt_d   = '0;
                end
                S_DW: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_dw) begin
                        state_d = S_DWD;
                        cnt_d   = '0;
                    end
                end
                S_DWD: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_lat) begin
                        state_d = S_PW;
                        cnt_d   = '0;
                        ic_d    = '0;
                        oc_d    = '0;
                    end
                end
                S_PW: begin
                    if (last_ic) begin
                        ic_d = '0;
                        if (last_oc) begin
                            state_d = S_PWD;
                            cnt_d   = '0;
                        end else begin
                            oc_d = oc_q + CH_W'(1);
                        end
                    end else begin
                        ic_d = ic_q + CH_W'(1);
                    end
                end
                S_PWD: begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_lat) begin
                        cnt_d = '0;
                        if (win_last) begin
                            win_d   = '0;
                            state_d = S_IDLE;
                        end else begin
                            win_d   = win_q + WIN_W'(1);
                            state_d = S_WAIT;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // outputs decoded from state and counters; enables and pulses gated by stall
    always_comb begin
        win_ready   = (state_q == S_WAIT);
        busy        = (state_q != S_IDLE);
        dw_en       = 1'b0;
        dw_grp      = '0;
        dw_addr     = '0;
        pw_en       = 1'b0;
        pw_ic       = '0;
        pw_oc       = '0;
        pw_addr     = '0;
        pw_acc_clr  = 1'b0;
        window_done = 1'b0;
        layer_done  = 1'b0;
        out_valid   = vld_line_q[PIPE_LAT-1];
        out_oc      = oc_line_q[PIPE_LAT-1];
        if (state_q == S_DW) begin
            dw_en   = ~stall;
            dw_grp  = CH_W'(cnt_q);
            dw_addr = dw_base_q + DW_ADDR_W'(cnt_q);
        end
        if (state_q == S_PW) begin
            pw_en      = ~stall;
            pw_ic      = ic_q;
            pw_oc      = oc_q;
            pw_addr    = pw_base_q + PW_ADDR_W'(pw_off);
            pw_acc_clr = ~stall & (ic_q == '0);
        end
        if (state_q == S_PWD && last_lat && !stall) begin
            window_done = 1'b1;
            layer_done  = win_last;
        end
    end
endmodule

// File: tb/tb_dsconv_sched.sv
module tb_dsconv_sched;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] cfg_in_ch = '0, cfg_out_ch = '0, cfg_out_size = '0;
    logic [4:0] cfg_dw_base = '0;
    logic [7:0] cfg_pw_base = '0;
    logic       win_valid = 1'b1;
    logic       out_ready = 1'b1;
    logic       win_ready, dw_en, pw_en, pw_acc_clr, out_valid, window_done, layer_done, busy;
    logic [7:0] dw_grp, pw_ic, pw_oc, pw_addr, out_oc;
    logic [4:0] dw_addr;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cyc = 0;
    int last_dw = 0;
    int first_pw = -1;
    int wd_n = 0, ld_n = 0, ld_wd = 0, wr_bad = 0;
    int dw_q[$], pw_q[$], clr_q[$], oc_q[$], occ_q[$];

    dsconv_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_in_ch(cfg_in_ch), .cfg_out_ch(cfg_out_ch), .cfg_out_size(cfg_out_size),
        .cfg_dw_base(cfg_dw_base), .cfg_pw_base(cfg_pw_base),
        .win_valid(win_valid), .win_ready(win_ready), .out_ready(out_ready),
        .dw_en(dw_en), .dw_grp(dw_grp), .dw_addr(dw_addr),
        .pw_en(pw_en), .pw_ic(pw_ic), .pw_oc(pw_oc), .pw_addr(pw_addr), .pw_acc_clr(pw_acc_clr),
        .out_valid(out_valid), .out_oc(out_oc),
        .window_done(window_done), .layer_done(layer_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // event log, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (win_valid && win_ready) hs_cyc = cyc;
            if (win_ready && (dw_en || pw_en || out_valid)) wr_bad++;
            if (dw_en) begin dw_q.push_back(int'(dw_addr)); last_dw = cyc; end
            if (pw_en) begin
                pw_q.push_back(int'(pw_addr));
                clr_q.push_back(int'(pw_acc_clr));
                if (first_pw < 0) first_pw = cyc;
            end
            if (out_valid && out_ready) oc_q.push_back(int'(out_oc));
            if (window_done) begin wd_n++; occ_q.push_back(cyc - hs_cyc); end
            if (layer_done) begin ld_n++; ld_wd = window_done ? wd_n : -1; end
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic launch(input int ic, input int oc, input int sz, input int dwb, input int pwb);
        cfg_in_ch = 8'(ic); cfg_out_ch = 8'(oc); cfg_out_size = 8'(sz);
        cfg_dw_base = 5'(dwb); cfg_pw_base = 8'(pwb);
        dw_q.delete(); pw_q.delete(); clr_q.delete(); oc_q.delete(); occ_q.delete();
        wd_n = 0; ld_n = 0; ld_wd = 0; wr_bad = 0; first_pw = -1;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_ld(input string tag, input int bound);
        int n = 0;
        while (ld_n == 0 && n < bound) begin @(posedge clk); #1; n++; end
        chk({tag, "_ld_seen"}, int'(ld_n != 0), 1);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_winrdy"}, int'(win_ready), 0);
        chk({tag, "_en"}, int'(dw_en | pw_en | pw_acc_clr), 0);
        chk({tag, "_outv"}, int'(out_valid), 0);
        chk({tag, "_done"}, int'(window_done | layer_done), 0);
        chk({tag, "_addr"}, int'(dw_addr) + int'(pw_addr) + int'(out_oc), 0);
    endtask

    initial begin
        #1 chk_idle_outs("reset");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // basic window: dw_t=8, ic_t=4, oc_t=8
        launch(32, 64, 1, 0, 0);
        wait_ld("basic", 200);
        chk("basic_dw_n", dw_q.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("basic_dw_addr%0d", i), qget(dw_q, i), i);
        chk("basic_dw_start", last_dw - hs_cyc, 8);
        chk("basic_pw_start", first_pw - hs_cyc, 12);
        chk("basic_pw_n", pw_q.size(), 32);
        for (int i = 0; i < 32; i++) begin
            chk($sformatf("basic_pw_addr%0d", i), qget(pw_q, i), i);
            chk($sformatf("basic_clr%0d", i), qget(clr_q, i), (i % 4 == 0) ? 1 : 0);
        end
        chk("basic_out_n", oc_q.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("basic_oc%0d", i), qget(oc_q, i), i);
        chk("basic_occ", qget(occ_q, 0), 46);
        chk("basic_ld_n", ld_n, 1);
        chk("basic_ld_with_wd", ld_wd, 1);
        chk("basic_idle_after", int'(busy), 0);

        // bases and rounding: dw_t=3, ic_t=2, oc_t=1
        launch(12, 8, 1, 9, 20);
        wait_ld("bases", 200);
        chk("bases_dw_n", dw_q.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("bases_dw_addr%0d", i), qget(dw_q, i), 9 + i);
        chk("bases_pw_n", pw_q.size(), 2);
        chk("bases_pw_addr0", qget(pw_q, 0), 20);
        chk("bases_pw_addr1", qget(pw_q, 1), 21);
        chk("bases_out_n", oc_q.size(), 1);
        chk("bases_occ", qget(occ_q, 0), 11);

        // multi-window with a start pulse while busy
        launch(8, 8, 2, 0, 0);
        repeat (5) begin @(posedge clk); #1; end
        cfg_out_size = 8'd1;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_ld("multi", 500);
        chk("multi_wd_n", wd_n, 4);
        chk("multi_ld_n", ld_n, 1);
        chk("multi_ld_on_4th", ld_wd, 4);
        chk("multi_winrdy_clean", wr_bad, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("multi_occ%0d", i), qget(occ_q, i), 9);

        // backpressure: 5 stalled cycles at the first out_valid
        launch(32, 64, 1, 0, 0);
        begin
            int n = 0;
            while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
        end
        chk("bp_outv_seen", int'(out_valid), 1);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold_v%0d", i), int'(out_valid), 1);
            chk($sformatf("bp_hold_oc%0d", i), int'(out_oc), 0);
            chk($sformatf("bp_pwen%0d", i), int'(pw_en | pw_acc_clr), 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        wait_ld("bp", 200);
        chk("bp_occ", qget(occ_q, 0), 51);
        chk("bp_pw_n", pw_q.size(), 32);
        chk("bp_out_n", oc_q.size(), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_oc%0d", i), qget(oc_q, i), i);
        chk("bp_ld_n", ld_n, 1);

        // reset mid-PW, then a clean layer
        launch(32, 64, 1, 0, 0);
        begin
            int n = 0;
            while (pw_q.size() < 5 && n < 200) begin @(posedge clk); #1; n++; end
        end
        chk("rst_in_pw", int'(pw_en), 1);
        #2 rst = 1'b1;
        #1 chk_idle_outs("rst_async");
        repeat (2) begin @(posedge clk); #1; end
        chk("rst_no_ld", ld_n, 0);
        rst = 1'b0;
        launch(12, 8, 1, 9, 20);
        wait_ld("post_rst", 200);
        chk("post_rst_dw_n", dw_q.size(), 3);
        chk("post_rst_dw_addr0", qget(dw_q, 0), 9);
        chk("post_rst_pw_addr1", qget(pw_q, 1), 21);
        chk("post_rst_occ", qget(occ_q, 0), 11);

        // zero configuration
        launch(0, 0, 0, 0, 0);
        wait_ld("zero", 200);
        chk("zero_dw_n", dw_q.size(), 1);
        chk("zero_pw_n", pw_q.size(), 1);
        chk("zero_clr", qget(clr_q, 0), 1);
        chk("zero_out_n", oc_q.size(), 1);
        chk("zero_wd_n", wd_n, 1);
        chk("zero_ld_n", ld_n, 1);
        chk("zero_occ", qget(occ_q, 0), 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
